// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the fetch (F)
// and data-memory (M) stages. M wins simultaneous requests; the stage that
// just completed is never re-granted directly, so contention alternates.
// Optional build macro MEM_TIMEOUT_EN adds a bus_err output and aborts an
// access that sees no mem_ack within TIMEOUT wait cycles.
//
// state | meaning
// IDLE  | no access in flight, mem_req low
// I_ACC | fetch access in flight on the memory port
// D_ACC | data access in flight on the memory port
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ready,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
`ifdef MEM_TIMEOUT_EN
  output logic          bus_err,
`endif
  output logic          stall_f,
  output logic          stall_m
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    I_ACC = 2'd1,
    D_ACC = 2'd2
  } state_t;

  localparam logic [31:0] ABORT_DATA = 32'hDEADBEEF;

  generate
    if (TIMEOUT < 1) begin : g_bad_timeout
      $error("mem_port_arbiter: TIMEOUT must be at least 1");
    end
  endgenerate

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic          grant_i;
  logic          grant_d;
  logic          done;
  logic          timeout_hit;
  logic [DW-1:0] rsp_data;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  // Abort fires when the wait counter has reached TIMEOUT and ack is still absent.
  always_comb begin
    timeout_hit = (state_q != IDLE) && !mem_ack && (cnt_q == CW'(TIMEOUT));
  end

  // Wait counter: cleared on every grant, counts ack-less cycles of an access.
  always_comb begin
    cnt_d = cnt_q;
    if (grant_i || grant_d) begin
      cnt_d = '0;
    end else if ((state_q != IDLE) && !mem_ack && (cnt_q != CW'(TIMEOUT))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Wait counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus_err = timeout_hit;
`else
  // Without the timeout option the arbiter waits for mem_ack indefinitely.
  always_comb begin
    timeout_hit = 1'b0;
  end
`endif

  // Completion decode, ready/rdata generation and next-state selection.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    i_ready  = 1'b0;
    d_ready  = 1'b0;
    i_rdata  = '0;
    d_rdata  = '0;
    done     = mem_ack || timeout_hit;
    rsp_data = timeout_hit ? DW'(ABORT_DATA) : mem_rdata;

    case (state_q)
      IDLE: begin
        if (d_req) begin
          grant_d = 1'b1;
        end else if (i_req) begin
          grant_i = 1'b1;
        end
      end
      I_ACC: begin
        if (done) begin
          i_ready = 1'b1;
          i_rdata = rsp_data;
          state_d = IDLE;
          // An aborted access returns to IDLE rather than handing over.
          if (d_req && !timeout_hit) begin
            grant_d = 1'b1;
          end
        end
      end
      D_ACC: begin
        if (done) begin
          d_ready = 1'b1;
          d_rdata = rsp_data;
          state_d = IDLE;
          if (i_req && !timeout_hit) begin
            grant_i = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (grant_d) begin
      state_d = D_ACC;
      addr_d  = d_addr;
      we_d    = d_we;
      wdata_d = d_wdata;
    end else if (grant_i) begin
      state_d = I_ACC;
      addr_d  = i_addr;
      we_d    = 1'b0;
    end
  end

  // State and latched access registers; held stable for the whole access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_req   = (state_q != IDLE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign stall_f = i_req & ~i_ready;
  assign stall_m = d_req & ~d_ready;

endmodule
